// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the icache and the dcache.
// The dcache normally wins. A starvation counter makes sure the icache still
// makes progress. Accesses are one word each. Every completion is followed by
// one IDLE turnaround cycle, so a cache has time to drop a request it has
// already retired before the arbiter could grant it again.
module mem_arbiter #(
    parameter int unsigned IMAX_WAIT = 4  // legal range 1..15
) (
    input  logic        CLK,
    input  logic        nRST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ram_state_t;

    localparam logic [3:0] IMAX = 4'(IMAX_WAIT);

    state_t     state_q, state_d;
    logic [3:0] scnt_q, scnt_d;
    logic       dreq;
    ram_state_t rs;

    assign dreq = dREN | dWEN;
    assign rs   = ram_state_t'(ramstate);

    // State and starvation-counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, whatever order the
    // assignments are written in.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    // Next-state, counter update and all outputs. The outputs depend only on
    // the current state and the inputs, so an asynchronous reset moves them
    // straight back to their IDLE values.
    // NOTE: every output and next-state signal gets a default before the case
    // statement. A path that does not assign a signal would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        mem_err  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!iREN) scnt_d = '0;
                if (dreq && (scnt_q != IMAX)) state_d = DGNT;
                else if (iREN)                state_d = IGNT;
                else if (dreq)                state_d = DGNT;
                else                          state_d = IDLE;
            end

            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                if (!dreq) begin
                    // Request withdrawn: enables stay low, nothing completes.
                    state_d = IDLE;
                end else begin
                    ramWEN = dWEN;              // a write wins over a read
                    ramREN = dREN & ~dWEN;
                    unique case (rs)
                        RAM_ACCESS: begin
                            dwait   = 1'b0;
                            state_d = IDLE;
                            if (iREN && (scnt_q != IMAX)) scnt_d = scnt_q + 4'd1;
                        end
                        RAM_ERROR: mem_err = 1'b1;  // hold the grant and retry
                        default: ;                  // FREE/BUSY: keep waiting
                    endcase
                end
            end

            IGNT: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN = 1'b1;
                    iload  = ramload;
                    unique case (rs)
                        RAM_ACCESS: begin
                            iwait   = 1'b0;
                            scnt_d  = '0;
                            state_d = IDLE;
                        end
                        RAM_ERROR: mem_err = 1'b1;
                        default: ;
                    endcase
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter one cycle at a time and compares the
// outputs with values worked out by hand. IMAX_WAIT is set to 2, so the
// grant order D, D, I can be seen in a short sequence.
module tb_mem_arbiter;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    typedef struct packed {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [1:0]  rs;
        logic [31:0] rl;
    } in_t;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] iload;
        logic [31:0] dload;
        logic        iwait;
        logic        dwait;
        logic        err;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    out_t act;
    assign act = '{ren: ramREN, wen: ramWEN, addr: ramaddr, store: ramstore,
                   iload: iload, dload: dload, iwait: iwait, dwait: dwait, err: mem_err};

    mem_arbiter #(.IMAX_WAIT(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    function automatic in_t mk_in(logic ir, logic [31:0] ia, logic dr, logic dw,
                                  logic [31:0] da, logic [31:0] ds,
                                  logic [1:0] rs, logic [31:0] rl);
        in_t v;
        v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw;
        v.daddr = da; v.dstore = ds; v.rs = rs; v.rl = rl;
        return v;
    endfunction

    function automatic out_t mk_out(logic ren, logic wen, logic [31:0] addr,
                                    logic [31:0] store, logic [31:0] il,
                                    logic [31:0] dl, logic iw, logic dw, logic err);
        out_t o;
        o.ren = ren; o.wen = wen; o.addr = addr; o.store = store;
        o.iload = il; o.dload = dl; o.iwait = iw; o.dwait = dw; o.err = err;
        return o;
    endfunction

    // Outputs seen in IDLE and while in reset.
    out_t o_idle;

    task automatic apply(input in_t v);
        iREN = v.iren; iaddr = v.iaddr; dREN = v.dren; dWEN = v.dwen;
        daddr = v.daddr; dstore = v.dstore; ramstate = v.rs; ramload = v.rl;
    endtask

    task automatic check(input string name, input out_t e);
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h iload=%h dload=%h iwait=%b dwait=%b err=%b | want ren=%b wen=%b addr=%h store=%h iload=%h dload=%h iwait=%b dwait=%b err=%b",
                     name, act.ren, act.wen, act.addr, act.store, act.iload, act.dload,
                     act.iwait, act.dwait, act.err, e.ren, e.wen, e.addr, e.store,
                     e.iload, e.dload, e.iwait, e.dwait, e.err);
        end
    endtask

    // One cycle: drive the inputs just after the rising edge, compare on the
    // falling edge, then advance to just after the next rising edge.
    task automatic step(input string name, input in_t v, input out_t e);
        apply(v);
        @(negedge CLK);
        check(name, e);
        @(posedge CLK);
        #1;
    endtask

    // Both caches request continuously. Every grant completes at once.
    // pattern holds the grant order the arbitration rule should produce.
    task automatic run_grants(input string tag, input string pattern);
        for (int k = 0; k < pattern.len(); k++) begin
            logic [31:0] ds, rl;
            ds = 32'h5A5A_0000 + 32'(k);
            rl = 32'hC0DE_0000 + 32'(k);
            step($sformatf("%s_idle%0d", tag, k),
                 mk_in(1, 32'h100, 1, 0, 32'h200, ds, FREE, 32'h0), o_idle);
            if (pattern[k] == "D")
                step($sformatf("%s_D%0d", tag, k),
                     mk_in(1, 32'h100, 1, 0, 32'h200, ds, ACCESS, rl),
                     mk_out(1, 0, 32'h200, ds, 32'h0, rl, 1, 0, 0));
            else
                step($sformatf("%s_I%0d", tag, k),
                     mk_in(1, 32'h100, 1, 0, 32'h200, ds, ACCESS, rl),
                     mk_out(1, 0, 32'h100, 32'h0, rl, 32'h0, 0, 1, 0));
        end
        step($sformatf("%s_drop", tag), mk_in(0, 0, 0, 0, 0, 0, FREE, 0), o_idle);
    endtask

    vec_t tbl[$];

    initial begin
        o_idle = mk_out(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 0);

        // Icache read: BUSY twice, then ACCESS.
        tbl.push_back('{"i_req_idle", mk_in(1, 32'h40, 0, 0, 0, 0, BUSY, 0), o_idle});
        tbl.push_back('{"i_busy1",    mk_in(1, 32'h40, 0, 0, 0, 0, BUSY, 0),
                        mk_out(1, 0, 32'h40, 0, 0, 0, 1, 1, 0)});
        tbl.push_back('{"i_busy2",    mk_in(1, 32'h40, 0, 0, 0, 0, BUSY, 0),
                        mk_out(1, 0, 32'h40, 0, 0, 0, 1, 1, 0)});
        tbl.push_back('{"i_access",   mk_in(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h8C01_0004),
                        mk_out(1, 0, 32'h40, 0, 32'h8C01_0004, 0, 0, 1, 0)});
        tbl.push_back('{"i_turnaround", mk_in(1, 32'h40, 0, 0, 0, 0, FREE, 0), o_idle});
        tbl.push_back('{"i_release",  mk_in(0, 0, 0, 0, 0, 0, FREE, 0), o_idle});
        // Dcache write.
        tbl.push_back('{"d_wr_idle",  mk_in(0, 0, 0, 1, 32'h3000, 32'hDEAD_BEEF, FREE, 0), o_idle});
        tbl.push_back('{"d_wr_busy",  mk_in(0, 0, 0, 1, 32'h3000, 32'hDEAD_BEEF, BUSY, 0),
                        mk_out(0, 1, 32'h3000, 32'hDEAD_BEEF, 0, 0, 1, 1, 0)});
        tbl.push_back('{"d_wr_access", mk_in(0, 0, 0, 1, 32'h3000, 32'hDEAD_BEEF, ACCESS, 32'h1234_5678),
                        mk_out(0, 1, 32'h3000, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1, 0, 0)});
        tbl.push_back('{"d_wr_done",  mk_in(0, 0, 0, 0, 0, 0, FREE, 0), o_idle});
        // dREN and dWEN together: the write wins.
        tbl.push_back('{"d_rw_idle",  mk_in(0, 0, 1, 1, 32'h8, 32'h5, FREE, 0), o_idle});
        tbl.push_back('{"d_rw_access", mk_in(0, 0, 1, 1, 32'h8, 32'h5, ACCESS, 32'hAA),
                        mk_out(0, 1, 32'h8, 32'h5, 0, 32'hAA, 1, 0, 0)});
        tbl.push_back('{"d_rw_done",  mk_in(0, 0, 0, 0, 0, 0, FREE, 0), o_idle});

        // Reset state.
        nRST = 1'b0;
        apply(mk_in(0, 0, 0, 0, 0, 0, FREE, 0));
        #12;
        check("reset", o_idle);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        foreach (tbl[i]) step(tbl[i].name, tbl[i].in, tbl[i].exp);

        // Both caches requesting with IMAX_WAIT=2: D, D, I, then D again
        // because the icache completion clears the counter.
        run_grants("prio", "DDID");

        // Dcache withdraws its read while the RAM is BUSY.
        step("wd_idle", mk_in(0, 0, 1, 0, 32'h50, 0, FREE, 0), o_idle);
        step("wd_busy", mk_in(0, 0, 1, 0, 32'h50, 0, BUSY, 0),
             mk_out(1, 0, 32'h50, 0, 0, 0, 1, 1, 0));
        step("wd_drop", mk_in(0, 0, 0, 0, 32'h50, 0, BUSY, 0),
             mk_out(0, 0, 32'h50, 0, 0, 0, 1, 1, 0));
        step("wd_idle_after", mk_in(0, 0, 0, 0, 32'h50, 0, ACCESS, 0), o_idle);

        // One ERROR cycle, then a normal completion.
        step("err_idle", mk_in(0, 0, 1, 0, 32'h60, 0, FREE, 0), o_idle);
        step("err_pulse", mk_in(0, 0, 1, 0, 32'h60, 0, ERROR, 0),
             mk_out(1, 0, 32'h60, 0, 0, 0, 1, 1, 1));
        step("err_retry", mk_in(0, 0, 1, 0, 32'h60, 0, ACCESS, 32'h77),
             mk_out(1, 0, 32'h60, 0, 0, 32'h77, 1, 0, 0));
        step("err_done", mk_in(0, 0, 0, 0, 0, 0, FREE, 0), o_idle);

        // Build scnt=1, enter IGNT, then assert reset in the middle of the grant.
        step("rst_idle", mk_in(1, 32'h80, 1, 0, 32'h90, 0, FREE, 0), o_idle);
        step("rst_d", mk_in(1, 32'h80, 1, 0, 32'h90, 0, ACCESS, 32'h1),
             mk_out(1, 0, 32'h90, 0, 0, 32'h1, 1, 0, 0));
        step("rst_idle2", mk_in(1, 32'h80, 0, 0, 0, 0, FREE, 0), o_idle);
        step("rst_ignt", mk_in(1, 32'h80, 0, 0, 0, 0, BUSY, 32'h2),
             mk_out(1, 0, 32'h80, 0, 32'h2, 0, 1, 1, 0));
        nRST = 1'b0;
        #1;
        check("rst_mid_grant", o_idle);
        @(posedge CLK);
        #1;
        check("rst_held", o_idle);
        nRST = 1'b1;
        // A counter left at 1 would give D, I. A cleared counter gives D, D, I.
        run_grants("post_rst", "DDI");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-ported RAM between the icache and the dcache control path.
- Issues one word access at a time and generates iwait/dwait.
- The dcache has priority. A bounded-starvation counter guarantees the icache forward progress.
- Sits directly below both caches and directly above the RAM model/controller.

Parameters:
- IMAX_WAIT, 4: consecutive dcache grants completed while the icache is waiting, before the icache is forced to win. Legal range 1..15.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous reset, active-low
- iREN  input  1  icache word read request
- iaddr  input  32  icache word address
- iload  output  32  instruction data to icache
- iwait  output  1  icache stall; low exactly one cycle on completion
- dREN  input  1  dcache word read request
- dWEN  input  1  dcache word write request
- daddr  input  32  dcache word address
- dstore  input  32  dcache write data
- dload  output  32  read data to dcache
- dwait  output  1  dcache stall; low exactly one cycle on completion
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- mem_err  output  1  one-cycle pulse when a granted access sees ERROR

Behaviour:
- States: IDLE, DGNT, IGNT. The state is registered.
- Reset values:
  - state=IDLE, starvation counter scnt=0.
  - ramREN=ramWEN=0; iwait=dwait=1; mem_err=0.
  - ramaddr, ramstore, iload and dload are all 0.
- Async reset mid-grant: outputs return to reset values immediately; no completion is signalled.
- IDLE:
  - No RAM enables.
  - Next state: DGNT if (dREN|dWEN) and scnt!=IMAX_WAIT; else IGNT if iREN; else DGNT if (dREN|dWEN); else IDLE.
  - Latency: a request sampled in IDLE drives the RAM from the next cycle.
- DGNT:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN: ramWEN=1, ramREN=0 (write wins if both are asserted). Else ramREN=dREN.
  - dload=ramload every cycle; iwait=1.
- IGNT:
  - ramREN=iREN, ramWEN=0, ramaddr=iaddr, iload=iREN ? ramload : 0.
  - dwait=1.
- Completion (ramstate==ACCESS while in a grant):
  - The granted wait output is low in that cycle only.
  - Next state is IDLE. A mandatory one-cycle turnaround prevents re-granting a request the cache has not yet retired.
- BUSY or FREE while granted: the wait stays high and the state holds.
- Request withdrawal: if the granted requester's enable(s) are all low while in the grant, the RAM enables drop combinationally and the next state is IDLE. No completion is signalled.
- ERROR while granted:
  - mem_err=1 for that cycle; the wait stays high; the state holds and the access retries.
- Starvation counter scnt:
  - Increments on each DGNT completion when iREN=1 in that cycle, saturating at IMAX_WAIT.
  - Clears on IGNT completion, and in any IDLE cycle with iREN=0.
- Simultaneous events:
  - Both requesting in IDLE with scnt<IMAX_WAIT: dcache is granted.
  - Both requesting with scnt==IMAX_WAIT: icache is granted.
- No combinational path from ramload to any wait output. iwait and dwait are never low in the same cycle.
- Widths: scnt is 4 bits. Address and data pass through unmodified; no byte-enable logic.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, and RAM returns BUSY for 2 cycles then ACCESS with ramload=0x8C010004 -> ramREN is high from cycle 1. iwait is low only in the ACCESS cycle with iload=0x8C010004. The next cycle is IDLE.
- dWEN=1, daddr=0x3000, dstore=0xDEADBEEF -> ramWEN=1 with matching addr/data. dwait pulses low once. mem_err stays 0.
- iREN and dREN asserted together from IDLE, IMAX_WAIT=2, dcache keeps requesting -> grant order is D, D, I, D. iwait falls only on the third completion. scnt returns to 0 afterwards.
- During DGNT with ramstate=BUSY, dREN drops -> ramREN=0 in the same cycle. IDLE follows next cycle. dwait never goes low.
- Granted read sees ramstate=ERROR for 1 cycle, then ACCESS -> mem_err is a single pulse and the wait stays high. Completion then occurs normally.
- nRST asserted while in IGNT -> ramREN=0 and iwait=1 immediately. After release the arbiter is in IDLE with scnt=0.
